// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module   : multicycle_ctrl_pkg
// Purpose  : Shared definitions for the multicycle RISC-V control unit:
//            FSM state codes, opcode constants, datapath mux encodings and
//            the immediate-format helper function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

  // FSM state codes
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BEQ      = 4'd9;
  localparam state_t S_JAL      = 4'd10;
  localparam state_t S_JALR1    = 4'd11;
  localparam state_t S_JALR2    = 4'd12;
  localparam state_t S_LUI      = 4'd13;
  localparam state_t S_AUIPC    = 4'd14;
  localparam state_t S_TRAP     = 4'd15;

  // Opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // ALU A operand select
  localparam logic [1:0] ALUA_PC    = 2'b00;
  localparam logic [1:0] ALUA_OLDPC = 2'b01;
  localparam logic [1:0] ALUA_RS1   = 2'b10;
  localparam logic [1:0] ALUA_ZERO  = 2'b11;

  // ALU B operand select
  localparam logic [1:0] ALUB_RS2  = 2'b00;
  localparam logic [1:0] ALUB_IMM  = 2'b01;
  localparam logic [1:0] ALUB_FOUR = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Result select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] r;
    case (op)
      OP_STORE:          r = IMM_S;
      OP_BEQ:            r = IMM_B;
      OP_JAL:            r = IMM_J;
      OP_LUI, OP_AUIPC:  r = IMM_U;
      default:           r = IMM_I;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_imm_src_dec.sv
// ============================================================================
// Module   : imm_src_dec
// Purpose  : Combinational opcode -> immediate-format decoder.
// Ports    : i_op      [6:0]  opcode field of the instruction register
//            o_imm_src [2:0]  immediate format select
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_src_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [2:0] o_imm_src
);

  assign o_imm_src = imm_src_of(i_op);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Moore-style main controller of a multicycle RV32 datapath.
//            Sequences fetch/decode/execute/memory/writeback states and
//            drives the datapath enables and mux selects.
// Ports    : clk, rst (async, active-high)
//            op[6:0], Zero, mem_ready            - status inputs
//            PCWrite, IRWrite, MemWrite, RegWrite,
//            AdrSrc, mem_req, instr_done, illegal - 1-bit controls
//            ALUSrcA, ALUSrcB, ALUOp, ResultSrc   - 2-bit selects
//            ImmSrc[2:0]                          - immediate format
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned EN_UTYPE      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       mem_req,
  output logic       instr_done,
  output logic       illegal,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc
);

  localparam bit C_HANDSHAKE = (MEM_HANDSHAKE != 0);
  localparam bit C_UTYPE     = (EN_UTYPE != 0);

  state_t r_state;
  state_t w_next;
  logic   w_done;

  logic w_pc_write, w_ir_write, w_mem_write, w_reg_write;
  logic w_mem_req, w_instr_done, w_illegal;

  // Memory access completes this cycle (always, when not handshaking).
  assign w_done = C_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_done) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BEQ:            w_next = S_BEQ;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR1;
          OP_LUI:            w_next = C_UTYPE ? S_LUI   : S_TRAP;
          OP_AUIPC:          w_next = C_UTYPE ? S_AUIPC : S_TRAP;
          default:           w_next = S_TRAP;
        endcase
      end
      // IR still holds the instruction, so op picks load vs store here.
      S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (w_done) w_next = S_MEMWB;
      S_MEMWRITE: if (w_done) w_next = S_FETCH;
      S_MEMWB:    w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR1:    w_next = S_JALR2;
      S_JALR2:    w_next = S_ALUWB;
      S_LUI:      w_next = S_ALUWB;
      S_AUIPC:    w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_req    = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = ALUA_PC;
    ALUSrcB      = ALUB_RS2;
    ALUOp        = ALUOP_ADD;
    ResultSrc    = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        ALUSrcB    = ALUB_FOUR;
        ResultSrc  = RES_ALURES;
        w_ir_write = w_done;
        w_pc_write = w_done;
      end
      S_DECODE: begin
        ALUSrcA = ALUA_OLDPC;
        ALUSrcB = ALUB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = ALUA_RS1;
        ALUSrcB = ALUB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        w_mem_req = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc       = 1'b1;
        w_mem_req    = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = w_done;
      end
      S_MEMWB: begin
        ResultSrc    = RES_DATA;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = ALUA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = ALUA_RS1;
        ALUSrcB = ALUB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA      = ALUA_RS1;
        ALUOp        = ALUOP_SUB;
        w_pc_write   = Zero;
        w_instr_done = 1'b1;
      end
      S_JAL, S_JALR2: begin
        ALUSrcA    = ALUA_OLDPC;
        ALUSrcB    = ALUB_FOUR;
        w_pc_write = 1'b1;
      end
      S_JALR1: begin
        ALUSrcA = ALUA_RS1;
        ALUSrcB = ALUB_IMM;
      end
      S_LUI: begin
        ALUSrcA = ALUA_ZERO;
        ALUSrcB = ALUB_IMM;
      end
      S_AUIPC: begin
        ALUSrcA = ALUA_OLDPC;
        ALUSrcB = ALUB_IMM;
      end
      S_TRAP:  w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Reset must silence every side effect immediately, not at the next edge.
  assign PCWrite    = w_pc_write   & ~rst;
  assign IRWrite    = w_ir_write   & ~rst;
  assign MemWrite   = w_mem_write  & ~rst;
  assign RegWrite   = w_reg_write  & ~rst;
  assign mem_req    = w_mem_req    & ~rst;
  assign instr_done = w_instr_done & ~rst;
  assign illegal    = w_illegal    & ~rst;

  imm_src_dec u_imm_src_dec (
    .i_op      (op),
    .o_imm_src (ImmSrc)
  );

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1: 1 = memory states wait on mem_ready; 0 = memory states take exactly one cycle and mem_ready is ignored.
REQ-002 SHALL have parameter EN_UTYPE, default 1: 1 = lui/auipc decoded; 0 = both treated as illegal.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port op, input, 7, opcode field of the instruction register.
REQ-006 SHALL have port Zero, input, 1, ALU zero flag, used for beq.
REQ-007 SHALL have port mem_ready, input, 1, memory access completes this cycle.
REQ-008 SHALL have ports PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, mem_req, instr_done, illegal; output; 1 each.
REQ-009 SHALL have ports ALUSrcA, ALUSrcB, ALUOp, ResultSrc; output; 2 each. It SHALL have port ImmSrc, output, 3.

Function
REQ-010 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, JALR1, JALR2, LUI, AUIPC, TRAP.
REQ-011 FETCH SHALL drive: AdrSrc=0, mem_req=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite SHALL be driven equal to done. It SHALL go to DECODE when done, where done = mem_ready if MEM_HANDSHAKE, else 1.
REQ-012 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00 and SHALL select the next state from op as follows.
- 0000011 goes to MEMADR; 0100011 goes to MEMADR.
- 0110011 goes to EXECR; 0010011 goes to EXECI.
- 1100011 goes to BEQ; 1101111 goes to JAL; 1100111 goes to JALR1.
- 0110111 goes to LUI and 0010111 goes to AUIPC, only when EN_UTYPE=1.
- Any other opcode goes to TRAP.
REQ-013 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00. It SHALL go to MEMREAD for loads and to MEMWRITE for stores, using op held in IR.
REQ-014 MEMREAD SHALL drive AdrSrc=1, mem_req=1, ResultSrc=00. It SHALL hold until done, then go to MEMWB.
REQ-015 MEMWRITE SHALL drive AdrSrc=1, mem_req=1, ResultSrc=00 and MemWrite=1 every cycle of the access. It SHALL hold until done, then go to FETCH with instr_done=1 on the done cycle.
REQ-016 MEMWB SHALL drive ResultSrc=01, RegWrite=1, instr_done=1, then go to FETCH.
REQ-017 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10, then go to ALUWB. EXECI SHALL be identical except ALUSrcB=01.
REQ-018 ALUWB SHALL drive ResultSrc=00, RegWrite=1, instr_done=1, then go to FETCH.
REQ-019 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, instr_done=1, then go to FETCH.
REQ-020 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-021 JALR1 SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to JALR2. JALR2 SHALL drive the same outputs as JAL, then go to ALUWB.
REQ-022 LUI SHALL drive ALUSrcA=11 (zero), ALUSrcB=01, ALUOp=00. AUIPC SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00. Both SHALL go to ALUWB.
REQ-023 TRAP SHALL hold all write enables and mem_req at 0 and drive illegal=1. It SHALL leave only on reset.
REQ-024 ImmSrc SHALL be combinational from op: I/load/jalr=000, S=001, B=010, J=011, U=100, other=000.
REQ-025 Outputs not listed for a state SHALL be 0.
REQ-026 instr_done SHALL be a single-cycle pulse per retired instruction.

Reset
REQ-027 rst high SHALL asynchronously force state to FETCH.
REQ-028 While rst is high, PCWrite, IRWrite, MemWrite, RegWrite, mem_req, instr_done and illegal SHALL be 0.
REQ-029 Reset asserted in any state, including mid memory wait and TRAP, SHALL abandon the instruction with no further writes. The first FETCH cycle SHALL be the first edge after release.

Structure
REQ-030 Shared package SHALL hold the state enum, opcode constants, and ImmSrc/ALUOp/ResultSrc/ALUSrc encodings.
REQ-031 One sub-module, imm_src_dec (op to ImmSrc), is natural; next-state and output logic SHALL stay in multicycle_ctrl.

Verification
REQ-032 Case 1, lw with MEM_HANDSHAKE=1 and mem_ready low 2 cycles in FETCH and in MEMREAD: IRWrite pulses once, RegWrite pulses in MEMWB, 9 cycles total.
REQ-033 Case 2, beq with Zero=1 and then Zero=0: PCWrite=1 in BEQ only for Zero=1; both retire in 3 cycles.
REQ-034 Case 3, jalr: state sequence FETCH, DECODE, JALR1, JALR2, ALUWB; PCWrite in JALR2; RegWrite in ALUWB; instr_done once.
REQ-035 Case 4, op=0110111 with EN_UTYPE=0: TRAP, illegal=1 held; no writes for 20 cycles. With EN_UTYPE=1: LUI, ALUWB, ALUSrcA=11, RegWrite=1.
REQ-036 Case 5, rst asserted during a MEMWRITE wait: MemWrite and mem_req drop to 0 immediately; restart in FETCH.
REQ-037 Case 6, sw with MEM_HANDSHAKE=0 and mem_ready tied 0: 4 cycles; MemWrite=1 for exactly 1 cycle.
